// File: rtl/audio_pwm_driver.sv
// audio_pwm_driver
//   Turns the tone oscillator's one-cycle at_max strobe into an 8-bit waveform
//   sample, scales it by volume and drives a 256-cycle PWM speaker output.
//   A watchdog mutes the output if ticks stop arriving for IDLE_CYCLES cycles.
//
// Ports
//   clk       system clock (12 MHz)
//   rst       asynchronous reset, active-high
//   tick      waveform-step strobe, one cycle wide
//   enable    level; 0 forces IDLE
//   wave_sel  00 square, 01 sawtooth, 10 triangle, 11 silence
//   volume    amplitude scale 0..15
//   pwm_out   registered speaker drive
//   sample    duty value currently being played
//   active    high while in RUN
module audio_pwm_driver #(
  parameter int unsigned IDLE_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       enable,
  input  logic [1:0] wave_sel,
  input  logic [3:0] volume,
  output logic       pwm_out,
  output logic [7:0] sample,
  output logic       active
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  localparam logic [15:0] IDLE_LAST = 16'(IDLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]  phase_q, phase_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [7:0]  duty_q, duty_d;
  logic        pwm_q, pwm_d;
  logic        active_q, active_d;

  logic [7:0]  raw;
  logic [11:0] product;
  logic [7:0]  scaled;

  // Next-state logic; enable low overrides everything.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (tick) state_d = ST_RUN;
        ST_RUN:   if (!tick && (idle_cnt_q == IDLE_LAST)) state_d = ST_STALL;
        ST_STALL: if (tick) state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Waveform generation from the registered phase, then volume scaling.
  always_comb begin
    raw = 8'd0;
    case (wave_sel)
      2'b00:   raw = phase_q[7] ? 8'hFF : 8'h00;
      2'b01:   raw = phase_q;
      2'b10:   raw = phase_q[7] ? ~{phase_q[6:0], 1'b0} : {phase_q[6:0], 1'b0};
      default: raw = 8'd0;
    endcase
  end

  assign product = 12'(raw) * 12'(volume);
  assign scaled  = product[11:4];

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (tick || !enable || (state_q == ST_IDLE)) begin
      idle_cnt_d = 16'd0;
    end else if (state_q == ST_RUN) begin
      idle_cnt_d = idle_cnt_q + 16'd1;
    end

    phase_d = phase_q;
    if (!enable) begin
      phase_d = 8'd0;
    end else if (tick) begin
      phase_d = phase_q + 8'd1;
    end else if (state_q == ST_IDLE) begin
      phase_d = 8'd0;
    end

    pwm_cnt_d = (state_q == ST_IDLE) ? 8'd0 : pwm_cnt_q + 8'd1;

    // Duty is only reloaded at the period wrap, from the pre-increment phase,
    // so a coincident tick never leaks into the period being started.
    duty_d = duty_q;
    if (state_d != ST_RUN) begin
      duty_d = 8'd0;
    end else if (pwm_cnt_q == 8'hFF) begin
      duty_d = scaled;
    end

    pwm_d    = (state_q == ST_RUN) && (pwm_cnt_q < duty_q);
    active_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idle_cnt_q <= 16'd0;
      phase_q    <= 8'd0;
      pwm_cnt_q  <= 8'd0;
      duty_q     <= 8'd0;
      pwm_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      phase_q    <= phase_d;
      pwm_cnt_q  <= pwm_cnt_d;
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
      active_q   <= active_d;
    end
  end

  assign pwm_out = pwm_q;
  assign sample  = duty_q;
  assign active  = active_q;

endmodule

// File: tb/tb_audio_pwm_driver.sv
// Testbench for audio_pwm_driver. Two instances share the stimulus: one with
// the default watchdog length and one with IDLE_CYCLES=100. Stimulus pushes
// expected values into a queue; a monitor pops and compares them on the
// falling clock edge (or immediately on chk_ev for between-edge checks).
module tb_audio_pwm_driver;

  logic       clk;
  logic       rst;
  logic       tick_man;
  logic       tick_gen;
  logic       tick;
  logic       enable;
  logic [1:0] wave_sel;
  logic [3:0] volume;

  logic       pwm_d, pwm_wd;
  logic [7:0] sample_d, sample_wd;
  logic       active_d, active_wd;

  assign tick = tick_man | tick_gen;

  audio_pwm_driver dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .enable   (enable),
    .wave_sel (wave_sel),
    .volume   (volume),
    .pwm_out  (pwm_d),
    .sample   (sample_d),
    .active   (active_d)
  );

  audio_pwm_driver #(.IDLE_CYCLES(100)) dut_wd (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .enable   (enable),
    .wave_sel (wave_sel),
    .volume   (volume),
    .pwm_out  (pwm_wd),
    .sample   (sample_wd),
    .active   (active_wd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string name;
    bit    wd;
    bit    window;
    int    exp_sample;
    int    exp_active;
    int    exp_pwm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_busy = 1'b0;
  event chk_ev;

  int   tick_period = 0;
  int   ticks_sent  = 0;

  function automatic int sample_of(bit wd);
    return wd ? int'(sample_wd) : int'(sample_d);
  endfunction

  function automatic int active_of(bit wd);
    return wd ? int'(active_wd) : int'(active_d);
  endfunction

  function automatic int pwm_of(bit wd);
    return wd ? int'(pwm_wd) : int'(pwm_d);
  endfunction

  function automatic int cnt_of(bit wd);
    return wd ? int'(dut_wd.pwm_cnt_q) : int'(dut.pwm_cnt_q);
  endfunction

  task automatic check_val(input string name, input string field, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", name, field, act, exp);
    end else begin
      $display("ok   %s %s = %0d", name, field, act);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout, got no event expected one", name);
  endtask

  // Snapshot expectation; -1 marks a field as don't-care.
  task automatic push_exp(input string name, input bit wd, input int s, input int a, input int p);
    exp_t e;
    e.name = name; e.wd = wd; e.window = 1'b0;
    e.exp_sample = s; e.exp_active = a; e.exp_pwm = p;
    exp_q.push_back(e);
  endtask

  // Expected number of pwm_out high cycles over the next 256 cycles.
  task automatic push_win(input string name, input bit wd, input int highs);
    exp_t e;
    e.name = name; e.wd = wd; e.window = 1'b1;
    e.exp_sample = -1; e.exp_active = -1; e.exp_pwm = highs;
    exp_q.push_back(e);
  endtask

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    int   highs;
    forever begin
      @(negedge clk or chk_ev);
      while (exp_q.size() > 0) begin
        mon_busy = 1'b1;
        e = exp_q.pop_front();
        if (e.window) begin
          highs = pwm_of(e.wd);
          repeat (255) begin
            @(negedge clk);
            highs += pwm_of(e.wd);
          end
          check_val(e.name, "pwm_high_cycles", highs, e.exp_pwm);
        end else begin
          if (e.exp_sample >= 0) check_val(e.name, "sample", sample_of(e.wd), e.exp_sample);
          if (e.exp_active >= 0) check_val(e.name, "active", active_of(e.wd), e.exp_active);
          if (e.exp_pwm >= 0)    check_val(e.name, "pwm_out", pwm_of(e.wd), e.exp_pwm);
        end
        mon_busy = 1'b0;
      end
    end
  end

  // Periodic tick generator (tick_period=0 disables it).
  initial begin
    int cnt;
    cnt = 0;
    tick_gen = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tick_gen) ticks_sent++;
      tick_gen = 1'b0;
      if (tick_period != 0) begin
        cnt++;
        if (cnt >= tick_period) begin
          tick_gen = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0 && !mon_busy) return;
      step();
    end
    timeout_fail("monitor_drain");
  endtask

  task automatic wait_cnt(input bit wd, input int val);
    for (int i = 0; i < 600; i++) begin
      if (cnt_of(wd) == val) return;
      step();
    end
    timeout_fail("wait_pwm_cnt");
  endtask

  task automatic wait_ticks(input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (ticks_sent >= n) return;
      step();
    end
    timeout_fail("wait_ticks");
  endtask

  task automatic burst(input int n);
    tick_man = 1'b1;
    repeat (n) step();
    tick_man = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    tick_man = 1'b0;
    enable   = 1'b0;
    wave_sel = 2'b00;
    volume   = 4'd0;

    // Reset held with random inputs.
    for (int i = 0; i < 20; i++) begin
      step();
      tick_man = 1'($urandom_range(0, 1));
      enable   = 1'($urandom_range(0, 1));
      wave_sel = 2'($urandom_range(0, 3));
      volume   = 4'($urandom_range(0, 15));
      if (i % 5 == 4) begin
        push_exp("reset_hold", 1'b0, 0, 0, 0);
        push_exp("reset_hold_wd", 1'b1, 0, 0, 0);
      end
    end
    tick_man = 1'b0;
    enable   = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      repeat (100) step();
      push_exp("idle_after_reset", 1'b0, 0, 0, 0);
    end
    push_exp("idle_after_reset_wd", 1'b1, 0, 0, 0);
    wait_idle();

    // Square wave, volume 15, tick every 107 cycles.
    wave_sel = 2'b00;
    volume   = 4'd15;
    enable   = 1'b1;
    ticks_sent = 0;
    tick_period = 107;
    wait_ticks(1, 300);
    push_exp("square_first_tick", 1'b0, -1, 1, -1);
    wait_ticks(10, 2000);
    wait_cnt(1'b0, 255); step();
    wait_cnt(1'b0, 255); step();
    push_exp("square_low_half", 1'b0, 0, 1, -1);
    push_win("square_low_half", 1'b0, 0);
    wait_idle();
    wait_ticks(130, 15000);
    wait_cnt(1'b0, 255); step();
    wait_cnt(1'b0, 255); step();
    push_exp("square_high_half", 1'b0, 239, 1, -1);
    push_win("square_high_half", 1'b0, 239);
    wait_idle();
    tick_period = 0;
    repeat (2) step();

    // Enable drop mid-period.
    wait_cnt(1'b0, 100);
    push_exp("pre_enable_drop", 1'b0, 239, 1, 1);
    enable = 1'b0;
    step();
    push_exp("enable_drop_1", 1'b0, 0, 0, -1);
    step();
    push_exp("enable_drop_2", 1'b0, 0, 0, 0);
    wait_idle();

    // Triangle, volume 8: phase 64 then 192.
    wave_sel = 2'b10;
    volume   = 4'd8;
    enable   = 1'b1;
    burst(64);
    push_exp("triangle_run", 1'b0, -1, 1, -1);
    wait_cnt(1'b0, 255); step();
    push_exp("triangle_phase64", 1'b0, 64, 1, -1);
    burst(128);
    wait_cnt(1'b0, 255); step();
    push_exp("triangle_phase192", 1'b0, 63, 1, -1);
    wait_idle();

    // Coincident tick and wrap: sawtooth, phase 99.
    wave_sel = 2'b01;
    volume   = 4'd15;
    burst(163);
    wait_cnt(1'b0, 255);
    tick_man = 1'b1;
    step();
    tick_man = 1'b0;
    push_exp("coincident_tick_wrap", 1'b0, 92, 1, -1);
    wait_cnt(1'b0, 255); step();
    push_exp("sawtooth_phase100", 1'b0, 93, 1, -1);
    wait_idle();

    // Watchdog on the IDLE_CYCLES=100 instance.
    enable = 1'b0;
    repeat (2) step();
    wave_sel = 2'b00;
    volume   = 4'd15;
    enable   = 1'b1;
    burst(200);
    wait_cnt(1'b1, 255);
    tick_man = 1'b1;
    step();
    tick_man = 1'b0;
    push_exp("wd_loaded", 1'b1, 239, 1, -1);
    repeat (99) step();
    push_exp("wd_before_stall", 1'b1, 239, 1, -1);
    step();
    push_exp("wd_stall_entry", 1'b1, 0, 0, -1);
    push_exp("default_no_stall", 1'b0, 239, 1, -1);
    step();
    push_exp("wd_stall_pwm", 1'b1, 0, 0, 0);
    repeat (50) step();
    push_exp("wd_stall_hold", 1'b1, 0, 0, 0);
    wait_cnt(1'b1, 200);
    tick_man = 1'b1;
    step();
    tick_man = 1'b0;
    push_exp("wd_resume", 1'b1, 0, 1, -1);
    wait_cnt(1'b1, 255); step();
    push_exp("wd_resume_boundary", 1'b1, 239, 1, -1);
    wait_idle();

    // Asynchronous reset pulse between clock edges.
    wait_cnt(1'b1, 10);
    push_exp("pre_async_reset", 1'b1, 239, 1, 1);
    ->chk_ev;
    #1 rst = 1'b1;
    #1;
    push_exp("async_reset_wd", 1'b1, 0, 0, 0);
    push_exp("async_reset", 1'b0, 0, 0, 0);
    ->chk_ev;
    #1 rst = 1'b0;
    repeat (10) step();
    push_exp("after_reset_no_tick", 1'b0, 0, 0, 0);
    push_exp("after_reset_no_tick_wd", 1'b1, 0, 0, 0);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_pwm_driver.md
# audio_pwm_driver

Consumer end of the tone oscillator's tick interface. Takes the oscillator's one-cycle `at_max` strobe as a waveform-step tick, generates an 8-bit waveform sample, scales it by volume and drives a single-bit PWM speaker output. A tick watchdog mutes the output when the oscillator stops ticking, so the speaker never holds a stale DC level.

## Interface
Parameters:
- `IDLE_CYCLES`, default 65535: clock cycles without a tick before the output is muted; 16-bit counter, legal values 1..65535.

Ports (reset is asynchronous and active-high; this is already decided):
- `clk`  in  1  system clock (12 MHz)
- `rst`  in  1  asynchronous reset, active-high
- `tick`  in  1  waveform-step strobe; one cycle wide; driven by the oscillator `at_max`
- `enable`  in  1  level; 0 forces IDLE
- `wave_sel`  in  2  00 square, 01 sawtooth, 10 triangle, 11 silence
- `volume`  in  4  amplitude scale, 0..15
- `pwm_out`  out  1  speaker drive
- `sample`  out  8  duty value currently being played
- `active`  out  1  high while in RUN

## Operation
- State machine with three states:
  - IDLE: `enable`=0.
  - RUN: ticks are arriving.
  - STALL: `enable`=1 but no tick has arrived for `IDLE_CYCLES` cycles.
- State transitions:
  - Any state -> IDLE whenever `enable`=0 (highest priority).
  - IDLE -> RUN on the first cycle with `enable`=1 and `tick`=1. With `enable`=1 and no tick, stay in IDLE.
  - RUN -> STALL when `idle_cnt` reaches `IDLE_CYCLES`-1 and `tick`=0.
  - STALL -> RUN on `tick`=1.
- `idle_cnt` (16-bit):
  - Cleared on `tick` and in IDLE.
  - Otherwise increments in RUN.
  - Holds in STALL.
- `phase` (8-bit):
  - Increments by 1 on each `tick` while `enable`=1, in any non-IDLE state and on the IDLE->RUN tick.
  - Wraps 255->0.
  - Cleared to 0 in IDLE.
- Raw waveform, computed combinationally from the registered `phase`:
  - Square: 255 if `phase[7]`, else 0.
  - Sawtooth: `phase`.
  - Triangle: `{phase[6:0],0}` if `phase[7]`=0, else the bitwise inverse of `{phase[6:0],0}`.
  - Silence: 0.
- Scaled value = (raw × `volume`) >> 4, using a 12-bit product and keeping bits [11:4]. Examples: raw 255, volume 15 -> 239; volume 0 -> 0.
- `pwm_cnt` (8-bit):
  - Free-runs 0..255 and wraps while the state is not IDLE.
  - Held at 0 in IDLE.
- `duty` register (drives `sample`):
  - Loaded with the scaled value on the edge where `pwm_cnt` wraps 255->0.
  - Forced to 0 in IDLE and STALL.
  - Inputs are sampled only at the period boundary, so a PWM period never changes duty mid-way.
- `pwm_out` is registered: next value = (state==RUN) && (`pwm_cnt` < `duty`).
  - `duty`=0 -> constant 0.
  - `duty`=255 -> high for 255 of every 256 cycles.
- Changes to `wave_sel` or `volume` take effect at the next period boundary only.

## Timing
- Reset values: `phase`=0, `pwm_cnt`=0, `duty`=0, `idle_cnt`=0, state IDLE, `pwm_out`=0, `sample`=0, `active`=0.
- Reset asserted mid-operation clears all of the above immediately and asynchronously, regardless of `clk`.
- `phase` changes on the edge after `tick` is sampled high.
- The duty load uses the pre-increment `phase`. If `tick` and the 255->0 wrap coincide, `duty` captures the old `phase`'s value.
- PWM period is 256 cycles, i.e. 46.875 kHz at 12 MHz.
- `pwm_out` lags the `pwm_cnt`/`duty` compare by 1 cycle.
- `active` is registered state decode: it rises on the edge that enters RUN and falls on the edge that leaves RUN.
- STALL entry: the edge at which `idle_cnt`=`IDLE_CYCLES`-1 with no tick.
  - `duty` is 0 from that edge.
  - `pwm_out` is 0 from the following edge.
- `enable` falling: state is IDLE on the next edge and `pwm_out` is 0 on the edge after.
- Back-to-back ticks (every cycle) are legal: `phase` increments every cycle.

## Test plan
- Reset check: hold `rst`=1 with random inputs -> all outputs 0. Release with `enable`=0 for 1000 cycles -> outputs stay 0 and state stays IDLE.
- Square wave:
  - Setup: `enable`=1, `wave_sel`=00, `volume`=15, `tick` every 107 cycles.
  - Required: `active`=1 after the first tick. While `phase`≥128, `sample`=239 and `pwm_out` is high exactly 239 of 256 cycles per period. While `phase`<128, `sample`=0.
- Triangle and scaling:
  - Setup: `wave_sel`=10, `volume`=8. Force `phase` to 64 via 64 ticks, then wait for a period boundary.
  - Required: `sample`=64 (raw 128, ×8 >> 4).
  - Then: after 128 more ticks (`phase`=192), `sample`=63 (raw 127).
- Coincident tick and wrap: apply `tick` on the cycle `pwm_cnt`=255 with `wave_sel`=01, `volume`=15, `phase`=99 -> `sample` = (99×15) >> 4 = 92, not 93.
- Watchdog:
  - Setup: `IDLE_CYCLES`=100. Tick once, then stop.
  - Required: `active` falls after 100 idle cycles, `sample`=0, and `pwm_out` is 0 one cycle later. A single tick then returns the block to RUN, and `sample` updates at the next boundary.
- Enable drop and async reset mid-run: drop `enable` mid-period -> `pwm_out`=0 within 2 cycles, and `phase`=0 when the block re-enters RUN. Pulse `rst` between clock edges during RUN -> outputs clear with no clock edge.
